// File: rtl/flash_reader.sv
// Streams a JPEG file from flash: issues open/read/close commands, walks the
// marker structure, captures SOF0 dimensions and pushes unstuffed entropy bytes.
module flash_reader (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         start,
  input  logic [159:0] file_name,
  input  logic         s_halt,
  input  logic [31:0]  read_data,
  input  logic [3:0]   read_be,
  input  logic         d_qual,
  input  logic         fifo_full,
  output logic [1:0]   m_cmd,
  output logic [159:0] f_name,
  output logic         m_halt,
  output logic [31:0]  line_width,
  output logic [31:0]  pic_height,
  output logic         dimensions_valid,
  output logic         fifo_wr,
  output logic [7:0]   fifo_wr_data,
  output logic         eof_out,
  output logic         error
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_OPEN  = 2'b01,
    CMD_READ  = 2'b10,
    CMD_CLOSE = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    P_IDLE, P_SOI_FF, P_SOI_D8, P_MARK_FF, P_MARK_CODE, P_LEN_H, P_LEN_L,
    P_SKIP, P_SOF, P_DATA, P_DATA_FF, P_DONE, P_ERR
  } parse_e;

  cmd_e               cmd_q, cmd_d;
  parse_e             ps_q, ps_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic               halt_d;
  logic [7:0]         code_q, code_d, len_hi_q, len_hi_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [2:0]         sof_idx_q, sof_idx_d;
  logic               sof_seen_q, sof_seen_d;
  logic [159:0]       fname_d;
  logic [31:0]        lw_d, ph_d;
  logic               dv_d, wr_d, eof_d, err_d;
  logic [7:0]         wr_data_d;
  logic [7:0]         cur_byte;
  logic [BE_W-1:0]    cur_lane;
  logic [LEN_W-1:0]   seg_len;
  logic               take;
  logic               parsing;

  assign m_cmd   = cmd_q;
  assign parsing = (ps_q != P_IDLE) && (ps_q != P_DONE) && (ps_q != P_ERR);

  // Next-state for command and parser FSMs plus all registered outputs.
  always_comb begin
    cmd_d      = cmd_q;
    ps_d       = ps_q;
    word_d     = word_q;
    be_d       = be_q;
    halt_d     = m_halt;
    code_d     = code_q;
    len_hi_d   = len_hi_q;
    rem_d      = rem_q;
    sof_idx_d  = sof_idx_q;
    sof_seen_d = sof_seen_q;
    fname_d    = f_name;
    lw_d       = line_width;
    ph_d       = pic_height;
    dv_d       = dimensions_valid;
    wr_d       = 1'b0;
    wr_data_d  = fifo_wr_data;
    eof_d      = 1'b0;
    err_d      = error;
    cur_byte   = 8'h00;
    cur_lane   = 4'b0000;
    seg_len    = '0;
    take       = 1'b0;

    // Highest-order valid lane of the held word is the next stream byte.
    if (be_q[3])      begin cur_byte = word_q[31:24]; cur_lane = 4'b1000; end
    else if (be_q[2]) begin cur_byte = word_q[23:16]; cur_lane = 4'b0100; end
    else if (be_q[1]) begin cur_byte = word_q[15:8];  cur_lane = 4'b0010; end
    else if (be_q[0]) begin cur_byte = word_q[7:0];   cur_lane = 4'b0001; end

    if (m_halt && parsing) begin
      take = 1'b1;
      case (ps_q)
        P_SOI_FF:  ps_d = (cur_byte == 8'hFF) ? P_SOI_D8 : P_ERR;
        P_SOI_D8:  ps_d = (cur_byte == 8'hD8) ? P_MARK_FF : P_ERR;
        P_MARK_FF: ps_d = (cur_byte == 8'hFF) ? P_MARK_CODE : P_ERR;
        P_MARK_CODE: begin
          if (cur_byte != 8'hFF) begin
            code_d = cur_byte;
            if (cur_byte == 8'hC0) sof_seen_d = 1'b1;
            ps_d = (cur_byte == 8'hDA && !sof_seen_q) ? P_ERR : P_LEN_H;
          end
        end
        P_LEN_H: begin
          len_hi_d = cur_byte;
          ps_d     = P_LEN_L;
        end
        P_LEN_L: begin
          seg_len   = {len_hi_q, cur_byte};
          rem_d     = seg_len - 16'd2;
          sof_idx_d = 3'd0;
          if (seg_len < 16'd2)       ps_d = P_ERR;
          else if (seg_len == 16'd2) ps_d = (code_q == 8'hDA) ? P_DATA : P_MARK_FF;
          else                       ps_d = (code_q == 8'hC0) ? P_SOF : P_SKIP;
        end
        P_SKIP: begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) ps_d = (code_q == 8'hDA) ? P_DATA : P_MARK_FF;
        end
        P_SOF: begin
          rem_d = rem_q - 16'd1;
          case (sof_idx_q)
            3'd1:    ph_d[15:8] = cur_byte;
            3'd2:    ph_d[7:0]  = cur_byte;
            3'd3:    lw_d[15:8] = cur_byte;
            3'd4:    begin lw_d[7:0] = cur_byte; dv_d = 1'b1; end
            default: ;
          endcase
          if (sof_idx_q != 3'd5) sof_idx_d = sof_idx_q + 3'd1;
          if (rem_q == 16'd1) ps_d = P_MARK_FF;
        end
        P_DATA: begin
          if (cur_byte == 8'hFF) ps_d = P_DATA_FF;
          else if (fifo_full)    take = 1'b0;
          else begin
            wr_d      = 1'b1;
            wr_data_d = cur_byte;
          end
        end
        P_DATA_FF: begin
          if (cur_byte == 8'h00) begin
            if (fifo_full) take = 1'b0;
            else begin
              wr_d      = 1'b1;
              wr_data_d = 8'hFF;
              ps_d      = P_DATA;
            end
          end else if (cur_byte == 8'hFF) begin
            ps_d = P_DATA_FF;
          end else if (cur_byte[7:3] == 5'b11010) begin
            ps_d = P_DATA;
          end else if (cur_byte == 8'hD9) begin
            eof_d = 1'b1;
            ps_d  = P_DONE;
          end else begin
            ps_d = P_ERR;
          end
        end
        default: ;
      endcase
      if (take) begin
        be_d = be_q & ~cur_lane;
        if ((be_q & ~cur_lane) == 4'b0000) halt_d = 1'b0;
      end
    end

    // Anything left in the held word after EOI or an error is dropped.
    if (ps_q == P_DONE || ps_q == P_ERR) begin
      halt_d = 1'b0;
      be_d   = '0;
    end

    if (cmd_q == CMD_READ && parsing && !m_halt && d_qual) begin
      word_d = read_data;
      be_d   = read_be;
      halt_d = |read_be;
    end

    if (ps_d == P_ERR) err_d = 1'b1;

    case (cmd_q)
      CMD_IDLE: begin
        if (start) begin
          cmd_d      = CMD_OPEN;
          ps_d       = P_SOI_FF;
          fname_d    = file_name;
          err_d      = 1'b0;
          dv_d       = 1'b0;
          lw_d       = '0;
          ph_d       = '0;
          halt_d     = 1'b0;
          be_d       = '0;
          sof_seen_d = 1'b0;
        end
      end
      CMD_OPEN:  if (!s_halt) cmd_d = CMD_READ;
      CMD_READ:  if (ps_q == P_DONE || ps_q == P_ERR) cmd_d = CMD_CLOSE;
      CMD_CLOSE: begin
        if (!s_halt) begin
          cmd_d = CMD_IDLE;
          if (ps_q == P_DONE) ps_d = P_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cmd_q            <= CMD_IDLE;
      ps_q             <= P_IDLE;
      word_q           <= '0;
      be_q             <= '0;
      m_halt           <= 1'b0;
      code_q           <= '0;
      len_hi_q         <= '0;
      rem_q            <= '0;
      sof_idx_q        <= '0;
      sof_seen_q       <= 1'b0;
      f_name           <= '0;
      line_width       <= '0;
      pic_height       <= '0;
      dimensions_valid <= 1'b0;
      fifo_wr          <= 1'b0;
      fifo_wr_data     <= '0;
      eof_out          <= 1'b0;
      error            <= 1'b0;
    end else begin
      cmd_q            <= cmd_d;
      ps_q             <= ps_d;
      word_q           <= word_d;
      be_q             <= be_d;
      m_halt           <= halt_d;
      code_q           <= code_d;
      len_hi_q         <= len_hi_d;
      rem_q            <= rem_d;
      sof_idx_q        <= sof_idx_d;
      sof_seen_q       <= sof_seen_d;
      f_name           <= fname_d;
      line_width       <= lw_d;
      pic_height       <= ph_d;
      dimensions_valid <= dv_d;
      fifo_wr          <= wr_d;
      fifo_wr_data     <= wr_data_d;
      eof_out          <= eof_d;
      error            <= err_d;
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
// Randomized bench for flash_reader: builds JPEG byte streams, predicts the
// outcome with a byte-walking reference parser and compares the DUT against it.
module tb_flash_reader;

  logic         clk_in = 1'b0;
  logic         rst, start, s_halt, d_qual, fifo_full;
  logic [159:0] file_name;
  logic [31:0]  read_data;
  logic [3:0]   read_be;
  logic [1:0]   m_cmd;
  logic [159:0] f_name;
  logic         m_halt, dimensions_valid, fifo_wr, eof_out, error;
  logic [31:0]  line_width, pic_height;
  logic [7:0]   fifo_wr_data;

  always #5 clk_in = ~clk_in;

  flash_reader dut (
    .clk_in(clk_in), .rst(rst), .start(start), .file_name(file_name),
    .s_halt(s_halt), .read_data(read_data), .read_be(read_be), .d_qual(d_qual),
    .fifo_full(fifo_full), .m_cmd(m_cmd), .f_name(f_name), .m_halt(m_halt),
    .line_width(line_width), .pic_height(pic_height),
    .dimensions_valid(dimensions_valid), .fifo_wr(fifo_wr),
    .fifo_wr_data(fifo_wr_data), .eof_out(eof_out), .error(error)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } word_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  byte_q[$];
  word_t       words_q[$];
  logic [7:0]  exp_push[$];
  bit          exp_err, exp_eof, exp_dv;
  logic [15:0] exp_w, exp_h;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_m_cmd"}, 32'(m_cmd), 32'd0);
    check_eq({tag, "_m_halt"}, 32'(m_halt), 32'd0);
    check_eq({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
    check_eq({tag, "_eof_out"}, 32'(eof_out), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_dims_valid"}, 32'(dimensions_valid), 32'd0);
    check_eq({tag, "_line_width"}, line_width, 32'd0);
    check_eq({tag, "_pic_height"}, pic_height, 32'd0);
    check_eq({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    check_eq({tag, "_f_name_zero"}, 32'(f_name == 160'd0), 32'd1);
  endtask

  task automatic add(input logic [7:0] b);
    byte_q.push_back(b);
  endtask

  task automatic add_sof(input logic [15:0] h, input logic [15:0] w);
    add(8'hFF); add(8'hC0); add(8'h00); add(8'h11); add(8'h08);
    add(h[15:8]); add(h[7:0]); add(w[15:8]); add(w[7:0]);
    for (int i = 0; i < 10; i++) add(8'($urandom));
  endtask

  task automatic add_sos();
    add(8'hFF); add(8'hDA); add(8'h00); add(8'h0C);
    for (int i = 0; i < 10; i++) add(8'($urandom));
  endtask

  // kind: 0 random valid, 1 sample picture, 2 restart drop, 3 bad SOI,
  // 4 SOS before SOF0, 5 short length, 6 bad code after FF in data
  task automatic build_stream(input int kind);
    int len, tok;
    byte_q.delete();
    if (kind == 3) begin
      add(8'h00); add(8'hD8); add(8'hFF); add(8'hD9);
      return;
    end
    add(8'hFF); add(8'hD8);
    case (kind)
      1: begin
        add(8'hFF); add(8'hE0); add(8'h00); add(8'h03); add(8'hAA);
        add_sof(16'h01E0, 16'h0280); add_sos();
        add(8'h12); add(8'hFF); add(8'h00); add(8'h34);
      end
      2: begin
        add_sof(16'($urandom), 16'($urandom)); add_sos();
        add(8'h55); add(8'hFF); add(8'hD3); add(8'h66);
      end
      4: begin add_sos(); add(8'h11); add(8'h22); end
      5: begin add(8'hFF); add(8'hE1); add(8'h00); add(8'h01); add(8'h33); end
      6: begin
        add_sof(16'($urandom), 16'($urandom)); add_sos();
        add(8'h34); add(8'hFF); add(8'h01); add(8'h56);
      end
      default: begin
        if ($urandom % 2 == 0) begin
          add(8'hFF);
          if ($urandom % 2 == 0) add(8'hFF);
          add(8'hE0 + 8'($urandom % 16));
          len = 2 + int'($urandom % 6);
          add(8'h00); add(8'(len));
          for (int i = 0; i < len - 2; i++) add(8'($urandom));
        end
        add_sof(16'($urandom), 16'($urandom));
        add_sos();
        add(8'($urandom % 255)); add(8'($urandom % 255));
        for (int i = 0; i < 6 + int'($urandom % 10); i++) begin
          tok = int'($urandom % 5);
          case (tok)
            2: begin add(8'hFF); add(8'h00); end
            3: begin add(8'hFF); add(8'hD0 + 8'($urandom % 8)); end
            4: begin add(8'hFF); add(8'hFF); add(8'h00); end
            default: add(8'($urandom % 255));
          endcase
        end
      end
    endcase
    add(8'hFF); add(8'hD9);
  endtask

  // Reference parser: jumps over whole segments by their declared length.
  task automatic run_model();
    int i, len;
    logic [7:0] code, b;
    bit sof;
    exp_push.delete();
    exp_err = 0; exp_eof = 0; exp_dv = 0; exp_w = 0; exp_h = 0; sof = 0;
    if (byte_q[0] != 8'hFF || byte_q[1] != 8'hD8) begin exp_err = 1; return; end
    i = 2;
    while (1) begin
      if (byte_q[i] != 8'hFF) begin exp_err = 1; return; end
      while (byte_q[i] == 8'hFF) i++;
      code = byte_q[i]; i++;
      if (code == 8'hDA && !sof) begin exp_err = 1; return; end
      len = {byte_q[i], byte_q[i+1]};
      i += 2;
      if (len < 2) begin exp_err = 1; return; end
      if (code == 8'hC0) begin
        sof = 1;
        if (len >= 7) begin
          exp_h  = {byte_q[i+1], byte_q[i+2]};
          exp_w  = {byte_q[i+3], byte_q[i+4]};
          exp_dv = 1;
        end
      end
      i += len - 2;
      if (code == 8'hDA) break;
    end
    while (i < byte_q.size()) begin
      b = byte_q[i]; i++;
      if (b != 8'hFF) exp_push.push_back(b);
      else begin
        while (byte_q[i] == 8'hFF) i++;
        b = byte_q[i]; i++;
        if (b == 8'h00) exp_push.push_back(8'hFF);
        else if (b == 8'hD9) begin exp_eof = 1; return; end
        else if (b < 8'hD0 || b > 8'hD7) begin exp_err = 1; return; end
      end
    end
  endtask

  // Packs bytes MSB-first into the lanes enabled by a (possibly random) mask.
  task automatic pack_words(input bit full_masks);
    int k;
    word_t w;
    k = 0;
    words_q.delete();
    while (k < byte_q.size()) begin
      w.data = $urandom;
      if (full_masks) w.be = 4'b1111;
      else case ($urandom % 8)
        0:       w.be = 4'b0000;
        1, 2, 3: w.be = 4'($urandom);
        default: w.be = 4'b1111;
      endcase
      for (int l = 3; l >= 0; l--) begin
        if (w.be[l]) begin
          if (k < byte_q.size()) begin
            w.data[l*8 +: 8] = byte_q[k];
            k++;
          end else w.be[l] = 1'b0;
        end
      end
      words_q.push_back(w);
    end
  endtask

  task automatic prepare(input int kind, input bit full_masks);
    build_stream(kind);
    run_model();
    pack_words(full_masks);
  endtask

  task automatic run_file(input string tag, input int n_open, input int n_close,
                          input bit stall_mode, input int abort_at);
    logic [159:0] name;
    logic [15:0]  cmd_log;
    logic [1:0]   last_cmd;
    logic [7:0]   got_q[$];
    word_t        w;
    int open_cnt, close_cnt, eof_cnt, full_push, stall_left, n;
    bit stalled, done;
    cmd_log = '0; last_cmd = 2'b00;
    open_cnt = 0; close_cnt = 0; eof_cnt = 0; full_push = 0; stall_left = 0;
    stalled = 0; done = 0;
    name = {$urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk_in);
    start = 1'b1; file_name = name;
    @(negedge clk_in);
    start = 1'b0;
    check_eq({tag, "_f_name_load"}, 32'(f_name == name), 32'd1);
    check_eq({tag, "_error_clr"}, 32'(error), 32'd0);
    check_eq({tag, "_dims_clr"}, 32'(dimensions_valid), 32'd0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (fifo_wr) begin
        got_q.push_back(fifo_wr_data);
        if (fifo_full) full_push++;
      end
      if (eof_out) eof_cnt++;
      if (m_cmd != last_cmd) begin
        cmd_log  = {cmd_log[11:0], 2'b00, m_cmd};
        last_cmd = m_cmd;
      end
      if (m_cmd == 2'b01) open_cnt++;
      if (m_cmd == 2'b11) close_cnt++;
      if (m_cmd == 2'b00) begin done = 1; break; end
      if (abort_at >= 0 && got_q.size() >= abort_at) begin
        rst = 1'b1; d_qual = 1'b0; start = 1'b0; fifo_full = 1'b0;
        @(negedge clk_in);
        reset_checks({tag, "_abort"});
        rst = 1'b0;
        return;
      end
      if (m_cmd == 2'b01)      s_halt = (open_cnt <= n_open);
      else if (m_cmd == 2'b11) s_halt = (close_cnt <= n_close);
      else                     s_halt = 1'($urandom);
      if (stall_mode) begin
        if (!stalled && got_q.size() >= 2) begin stalled = 1; stall_left = 5; end
        fifo_full = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else fifo_full = ($urandom % 4 == 0);
      if (m_cmd == 2'b10 && !m_halt && words_q.size() > 0 && $urandom % 4 != 0) begin
        w = words_q.pop_front();
        d_qual = 1'b1; read_data = w.data; read_be = w.be;
      end else begin
        d_qual = m_halt ? 1'($urandom) : 1'b0;
        read_data = $urandom; read_be = 4'($urandom);
      end
      start = (m_cmd == 2'b10) && ($urandom % 16 == 0);
      file_name = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk_in);
    end
    start = 1'b0; d_qual = 1'b0; fifo_full = 1'b0;
    if (!done) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    n = (got_q.size() < exp_push.size()) ? got_q.size() : exp_push.size();
    check_eq({tag, "_push_count"}, 32'(got_q.size()), 32'(exp_push.size()));
    for (int i = 0; i < n; i++) check_eq({tag, "_push_byte"}, 32'(got_q[i]), 32'(exp_push[i]));
    check_eq({tag, "_error"}, 32'(error), 32'(exp_err));
    check_eq({tag, "_eof_cycles"}, 32'(eof_cnt), 32'(exp_eof));
    check_eq({tag, "_dims_valid"}, 32'(dimensions_valid), 32'(exp_dv));
    check_eq({tag, "_pic_height"}, pic_height, 32'(exp_h));
    check_eq({tag, "_line_width"}, line_width, 32'(exp_w));
    check_eq({tag, "_cmd_seq"}, 32'(cmd_log), 32'h1230);
    check_eq({tag, "_open_cycles"}, 32'(open_cnt), 32'(n_open + 1));
    check_eq({tag, "_close_cycles"}, 32'(close_cnt), 32'(n_close + 1));
    check_eq({tag, "_push_while_full"}, 32'(full_push), 32'd0);
    check_eq({tag, "_m_halt_end"}, 32'(m_halt), 32'd0);
    check_eq({tag, "_f_name_kept"}, 32'(f_name == name), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_halt = 1'b0; d_qual = 1'b0; fifo_full = 1'b0;
    file_name = '0; read_data = '0; read_be = '0;
    repeat (3) @(negedge clk_in);
    reset_checks("reset");
    rst = 1'b0;

    prepare(1, 1'b1); run_file("ref_file", 3, 2, 1'b1, -1);
    prepare(2, 1'b0); run_file("rst_marker", 1, 0, 1'b0, -1);
    prepare(3, 1'b0); run_file("bad_soi", 0, 3, 1'b0, -1);
    prepare(4, 1'b0); run_file("sos_first", 2, 1, 1'b0, -1);
    prepare(5, 1'b0); run_file("short_len", 0, 0, 1'b0, -1);
    prepare(6, 1'b0); run_file("bad_code", 1, 2, 1'b0, -1);
    prepare(0, 1'b0); run_file("abort", 0, 0, 1'b0, 2);
    prepare(0, 1'b0); run_file("after_abort", 1, 1, 1'b0, -1);
    for (int t = 0; t < 10; t++) begin
      prepare(0, 1'($urandom));
      run_file("random", int'($urandom % 4), int'($urandom % 4), 1'($urandom % 4 == 0), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
